// File: rtl/branch_offset_narrow19.sv
`default_nettype none
// ============================================================================
// Module   : branch_offset_narrow19
// Purpose  : Narrows a 64-bit signed byte displacement into the OUT_W-bit
//            signed word-offset field of a CB-type branch. The value is
//            range-checked and misalignment is flagged. Out-of-range values
//            are either saturated or truncated. Flagged results are counted.
//            The block is a two-stage valid/ready pipeline with full
//            backpressure and a throughput of one value per cycle.
// Ports    : clk          - clock, rising edge
//            reset_n      - asynchronous active-low reset
//            in_valid     - input value offered
//            in_ready     - input accepted this cycle when high
//            in_value     - signed byte displacement [63:0]
//            out_valid    - result available
//            out_ready    - consumer accepts result
//            out_field    - encoded signed word offset [OUT_W-1:0]
//            out_ovf      - value did not fit in OUT_W bits after the shift
//            out_misalign - low SHIFT bits of in_value were nonzero
//            err_count    - saturating count of flagged results consumed
//            clear_err    - synchronous clear of err_count (wins over increment)
// Revision : 1.0 - initial release
// ============================================================================
module branch_offset_narrow19 #(
    parameter int OUT_W    = 19,
    parameter int SHIFT    = 2,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_field,
    output logic             out_ovf,
    output logic             out_misalign,
    output logic [CNT_W-1:0] err_count,
    input  logic             clear_err
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam int               c_up_w    = 64 - OUT_W + 1;

    // Stage 1: shifted value reduced to its low field bits plus sign and fit flag
    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_low_q,   s1_low_d;
    logic             s1_neg_q,   s1_neg_d;
    logic             s1_fits_q,  s1_fits_d;
    logic             s1_mis_q,   s1_mis_d;

    // Stage 2: encoded result presented on the outputs
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] s2_field_q, s2_field_d;
    logic             s2_ovf_q,   s2_ovf_d;
    logic             s2_mis_q,   s2_mis_d;

    logic [CNT_W-1:0] err_q, err_d;

    logic [63:0]       w_shifted;
    logic [c_up_w-1:0] w_upper;
    logic              w_fits;
    logic              w_mis;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_s2_load;
    logic [OUT_W-1:0]  w_sat_field;
    logic [OUT_W-1:0]  w_enc_field;

    // Arithmetic shift floors toward minus infinity for misaligned negatives
    assign w_shifted = $signed(in_value) >>> SHIFT;
    // The value fits when every bit from the field's sign bit upward matches
    assign w_upper   = w_shifted[63:OUT_W-1];
    assign w_fits    = (&w_upper) | ~(|w_upper);
    assign w_mis     = |in_value[SHIFT-1:0];

    assign w_out_hs  = s2_valid_q & out_ready;
    assign w_s2_load = ~s2_valid_q | w_out_hs;
    // Stage 1 frees up in the same cycle it moves into stage 2
    assign in_ready  = ~s1_valid_q | w_s2_load;
    assign w_in_hs   = in_valid & in_ready;

    generate
        if (SATURATE != 0) begin : g_sat
            // Clamp to the most positive or most negative field value
            assign w_sat_field = s1_neg_q ? {1'b1, {(OUT_W-1){1'b0}}}
                                          : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin : g_trunc
            assign w_sat_field = s1_low_q;
        end
    endgenerate

    assign w_enc_field = s1_fits_q ? s1_low_q : w_sat_field;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_low_d   = s1_low_q;
        s1_neg_d   = s1_neg_q;
        s1_fits_d  = s1_fits_q;
        s1_mis_d   = s1_mis_q;
        s2_valid_d = s2_valid_q;
        s2_field_d = s2_field_q;
        s2_ovf_d   = s2_ovf_q;
        s2_mis_d   = s2_mis_q;
        err_d      = err_q;

        if (w_in_hs) begin
            s1_valid_d = 1'b1;
            s1_low_d   = w_shifted[OUT_W-1:0];
            s1_neg_d   = w_shifted[63];
            s1_fits_d  = w_fits;
            s1_mis_d   = w_mis;
        end else if (w_s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (w_s2_load) begin
            s2_valid_d = s1_valid_q;
            // Data only moves with a real value so the outputs keep the last result
            if (s1_valid_q) begin
                s2_field_d = w_enc_field;
                s2_ovf_d   = ~s1_fits_q;
                s2_mis_d   = s1_mis_q;
            end
        end

        if (clear_err) begin
            err_d = '0;
        end else if (w_out_hs && (s2_ovf_q || s2_mis_q) && (err_q != c_cnt_max)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_low_q   <= '0;
            s1_neg_q   <= 1'b0;
            s1_fits_q  <= 1'b0;
            s1_mis_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_field_q <= '0;
            s2_ovf_q   <= 1'b0;
            s2_mis_q   <= 1'b0;
            err_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_low_q   <= s1_low_d;
            s1_neg_q   <= s1_neg_d;
            s1_fits_q  <= s1_fits_d;
            s1_mis_q   <= s1_mis_d;
            s2_valid_q <= s2_valid_d;
            s2_field_q <= s2_field_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_mis_q   <= s2_mis_d;
            err_q      <= err_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_field    = s2_field_q;
    assign out_ovf      = s2_ovf_q;
    assign out_misalign = s2_mis_q;
    assign err_count    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_offset_narrow19.sv
`default_nettype none
`timescale 1ns/1ns
// ============================================================================
// Module   : tb_branch_offset_narrow19
// Purpose  : Scoreboard bench for branch_offset_narrow19. One instance
//            saturates and one truncates, and both see the same stimulus.
//            Expected results are computed arithmetically from the input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_offset_narrow19;

    localparam int OUT_W = 19;
    localparam int SHIFT = 2;
    localparam int CNT_W = 16;

    typedef struct {
        longint           v;
        logic [OUT_W-1:0] fs;
        logic [OUT_W-1:0] ft;
        logic             ovf;
        logic             mis;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic [63:0]      in_value;
    logic             out_ready;
    logic             clear_err;
    logic             in_ready,  in_ready_t;
    logic             out_valid, out_valid_t;
    logic [OUT_W-1:0] out_field, out_field_t;
    logic             out_ovf,   out_ovf_t;
    logic             out_misalign, out_misalign_t;
    logic [CNT_W-1:0] err_count, err_count_t;

    int               checks = 0;
    int               errors = 0;
    int               acc_cnt = 0;
    int               target = 0;
    int               rdy_mode = 1;
    exp_t             sb[$];
    logic [CNT_W-1:0] err_exp;
    logic             held;
    logic [OUT_W-1:0] held_field;
    logic             held_ovf, held_mis;

    logic             ovr_en = 1'b0;
    logic [OUT_W-1:0] ovr_fs, ovr_ft;
    logic             ovr_ovf, ovr_mis;

    always #5 clk = ~clk;

    branch_offset_narrow19 #(.OUT_W(OUT_W), .SHIFT(SHIFT), .SATURATE(1), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
        .out_field(out_field), .out_ovf(out_ovf), .out_misalign(out_misalign),
        .err_count(err_count), .clear_err(clear_err)
    );

    branch_offset_narrow19 #(.OUT_W(OUT_W), .SHIFT(SHIFT), .SATURATE(0), .CNT_W(CNT_W)) u_dut_t (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_value(in_value), .out_valid(out_valid_t), .out_ready(out_ready),
        .out_field(out_field_t), .out_ovf(out_ovf_t), .out_misalign(out_misalign_t),
        .err_count(err_count_t), .clear_err(clear_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Word offset = floor(v / 2^SHIFT); range is the signed OUT_W-bit interval
    function automatic exp_t model(input longint v);
        exp_t   e;
        longint div, q, r, lim, qc;
        div = longint'(1) << SHIFT;
        lim = longint'(1) << (OUT_W - 1);
        q   = v / div;
        r   = v % div;
        if (r != 0 && v < 0) q = q - 1;
        qc    = (q < -lim) ? -lim : ((q > lim - 1) ? lim - 1 : q);
        e.v   = v;
        e.mis = (r != 0);
        e.ovf = (q < -lim) || (q > lim - 1);
        e.ft  = q[OUT_W-1:0];
        e.fs  = qc[OUT_W-1:0];
        return e;
    endfunction

    function automatic longint rand_val();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 32'h7F_FFFF)) - 64'sd4194304;
            1: v = longint'({$urandom(), $urandom()});
            2: v = (($urandom_range(0, 1) != 0) ? 64'sd1048576 : -64'sd1048576)
                   + longint'($urandom_range(0, 16)) - 64'sd8;
            default: v = (longint'($urandom_range(0, 32'h7FFFF)) - 64'sd262144) * 4;
        endcase
        return v;
    endfunction

    // out_ready driver: changes 2ns after each rising edge
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor/scoreboard: evaluates on the falling edge the handshakes that
    // the next rising edge will complete
    initial begin
        exp_t   e;
        logic   hs, flagged;
        longint rt;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                sb.delete();
                err_exp = '0;
                held    = 1'b0;
            end else begin
                check("err_count", err_count, err_exp);
                check("err_count_trunc", err_count_t, err_exp);
                if (held) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_field", out_field, held_field);
                    check("hold_flags", {held_ovf, held_mis}, {out_ovf, out_misalign});
                end
                held       = out_valid && !out_ready;
                held_field = out_field;
                held_ovf   = out_ovf;
                held_mis   = out_misalign;
                hs      = out_valid && out_ready;
                flagged = 1'b0;
                if (hs) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got field %0h required no output", out_field);
                        flagged = out_ovf | out_misalign;
                    end else begin
                        e = sb.pop_front();
                        check("field_sat", out_field, e.fs);
                        check("ovf", out_ovf, e.ovf);
                        check("misalign", out_misalign, e.mis);
                        check("valid_trunc", out_valid_t, 1);
                        check("field_trunc", out_field_t, e.ft);
                        check("ovf_trunc", out_ovf_t, e.ovf);
                        flagged = e.ovf | e.mis;
                        if (!e.ovf && !e.mis) begin
                            rt = longint'($signed(out_field)) <<< SHIFT;
                            check("round_trip", rt, e.v);
                        end
                    end
                end
                if (clear_err) err_exp = '0;
                else if (hs && flagged && err_exp != '1) err_exp = err_exp + 1'b1;
                if (in_valid && in_ready) begin
                    if (ovr_en) begin
                        e.v = in_value; e.fs = ovr_fs; e.ft = ovr_ft;
                        e.ovf = ovr_ovf; e.mis = ovr_mis;
                    end else begin
                        e = model(in_value);
                    end
                    sb.push_back(e);
                    acc_cnt++;
                end
            end
        end
    end

    task automatic offer(input longint v);
        in_valid = 1'b1;
        in_value = v;
        target   = acc_cnt + 1;
    endtask

    task automatic wait_acc();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (acc_cnt < target && n < 300);
        if (acc_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got %0d accepts required %0d", acc_cnt, target);
        end
    endtask

    task automatic send_d(input longint v, input logic [OUT_W-1:0] fs, input logic [OUT_W-1:0] ft,
                          input logic ovf, input logic mis);
        ovr_en = 1'b1; ovr_fs = fs; ovr_ft = ft; ovr_ovf = ovf; ovr_mis = mis;
        offer(v);
        wait_acc();
    endtask

    task automatic send_m(input longint v);
        ovr_en = 1'b0;
        offer(v);
        wait_acc();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        rdy_mode = 1;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", {63'b0, (sb.size() != 0 || out_valid)}, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_value = '0; clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_field", out_field, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_mis", out_misalign, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", in_ready, 1);

        // Misaligned values: still encoded, floor toward minus infinity
        send_d(6,  19'h00001, 19'h00001, 1'b0, 1'b1);
        send_d(-1, 19'h7FFFF, 19'h7FFFF, 1'b0, 1'b1);
        drain();
        check("err_after_misalign", err_count, 2);

        // Directed values and range boundaries
        send_d(58944,      19'h03990, 19'h03990, 1'b0, 1'b0);
        send_d(-58944,     19'h7C670, 19'h7C670, 1'b0, 1'b0);
        send_d(64'h100000, 19'h3FFFF, 19'h40000, 1'b1, 1'b0);
        send_d(-1048576,   19'h40000, 19'h40000, 1'b0, 1'b0);
        send_d(64'hFFFFC,  19'h3FFFF, 19'h3FFFF, 1'b0, 1'b0);
        drain();

        // Backpressure: capacity of two, third value waits
        rdy_mode = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        send_d(10, 19'd2, 19'd2, 1'b0, 1'b1);
        send_d(20, 19'd5, 19'd5, 1'b0, 1'b0);
        ovr_fs = 19'd7; ovr_ft = 19'd7; ovr_ovf = 1'b0; ovr_mis = 1'b1;
        offer(30);
        repeat (4) begin @(posedge clk); #1; end
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_field", out_field, 2);
        rdy_mode = 1;
        wait_acc();
        drain();

        // Random stream with random backpressure and idle gaps
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            send_m(rand_val());
        end
        drain();

        // Saturate the error counter with misaligned values
        for (int i = 0; i < 65540; i++) send_m(1);
        drain();
        check("err_saturated", err_count, 16'hFFFF);

        // Clear coincident with a flagged output handshake
        rdy_mode = 0;
        @(posedge clk); #1;
        send_m(5);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        clear_err = 1'b1;
        rdy_mode  = 1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        check("err_clear_wins", err_count, 0);
        drain();

        // Asynchronous reset pulse with two values in flight
        rdy_mode = 0;
        @(posedge clk); #1;
        send_m(40);
        send_m(44);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_err", err_count, 0);
        #1 reset_n = 1'b1;
        rdy_mode = 1;
        repeat (6) begin @(posedge clk); #1; end
        check("post_rst_no_output", out_valid, 0);
        check("post_rst_sb_empty", {32'b0, sb.size()}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
